conv33_window: RTL
==================

Name: conv33_window

Overview:
- Upstream feeder for the 3x3 convolution core.
- Accepts a raster-order pixel stream of one feature-map channel, one pixel per handshake.
- Buffers the two previous image rows and emits every fully-valid 3x3 window (no padding, stride 1) on nine parallel outputs wired directly to the core's data_in_r_c ports.
- Uses a valid/ready handshake on both sides with full backpressure.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_W, 28, image width in pixels; must be ≥ 3.
- IMG_H, 28, image height in pixels; must be ≥ 3.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pix_valid_in  in  1  upstream pixel valid.
- pix_ready_out  out  1  block can accept a pixel this cycle.
- pix_data  in  DATA_WIDTH  pixel value.
- win_valid_out  out  1  window outputs hold a valid 3x3 window.
- win_ready_in  in  1  downstream (conv core) accepts the window.
- win_0_0 … win_2_2 (9 ports)  out  DATA_WIDTH each  window element at row r, column c. Row 0 and column 0 are the oldest (top-left).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:

Reset and handshakes:
- Reset (rst=0, asynchronous): col/row counters = 0, win_valid_out = 0, frame_done = 0, all win_* = 0. Line-buffer contents are not cleared; they are don't-care because output is gated by the row count.
- pix_ready_out = !win_valid_out || win_ready_in (single output register stage, combinational ready).
- Pixel accept = pix_valid_in && pix_ready_out. No state changes in cycles without an accept, except that win_valid_out clears on a window accept.

Storage and counters:
- Two line buffers of depth IMG_W:
  - lb1 holds row r-1.
  - lb0 holds row r-2.
  - On accept at column c, read lb0[c] and lb1[c], then write lb0[c] ← lb1[c] and lb1[c] ← pix_data.
- Column/row counters:
  - col increments per accept.
  - At col = IMG_W-1, col wraps to 0 and row increments.
  - At row = IMG_H-1 and col = IMG_W-1, both wrap to 0 (next frame starts immediately, no gap cycle required).
- Window shift register: 3x3 regs. On accept, columns shift left (c0←c1←c2) and the new column c2 = {lb0[c], lb1[c], pix_data} for rows {0, 1, 2}.

Window output:
- On an accept with row ≥ 2 and col ≥ 2, win_valid_out = 1 on the next cycle, with window top-left at (row-2, col-2).
- On an accept that produces no window, with window accepted or none pending, win_valid_out = 0 next cycle.
- win_valid_out, once high, holds with stable win_* until win_ready_in = 1.
- Latency: exactly 1 cycle from the accepting edge to win_valid_out.
- Windows per frame: (IMG_H-2)*(IMG_W-2).
- Row wrap: windows do not straddle rows, because of the col ≥ 2 gate; the shift register refills naturally after the wrap.

Frame completion:
- frame_done pulses 1 cycle, registered, in the cycle after the accept of pixel (IMG_H-1, IMG_W-1).
- It coincides with win_valid_out for the last window.

Boundary cases:
- Simultaneous window accept and new pixel accept in one cycle: the new window replaces the old one without a bubble. Throughput is 1 pixel/cycle with win_ready_in tied high.
- Reset mid-frame: the partial frame is discarded; the next accepted pixel is treated as (0,0).

Test Plan:
1. IMG_W=4, IMG_H=4, pixels p = 4r+c streamed with win_ready_in=1 → exactly 4 windows:
   - after pixel 10: rows {0,1,2 | 4,5,6 | 8,9,10}
   - after 11: {1,2,3 | 5,6,7 | 9,10,11}
   - after 14: {4,5,6 | 8,9,10 | 12,13,14}
   - after 15: {5,6,7 | 9,10,11 | 13,14,15}
   - frame_done is high together with the 4th window, and pix_ready_out stays 1 throughout.
2. Same stream, win_ready_in=0 for 5 cycles after the first window → pix_ready_out=0, win_* hold {0..10} stable; on release, the remaining 3 windows arrive in order with no loss or duplication.
3. Random pix_valid_in gaps (50% duty) over two back-to-back 4x4 frames → 8 windows matching scenario 1 for each frame; frame_done pulses twice.
4. Reset asserted asynchronously after pixel 6 of a frame, then the full 4x4 frame is sent → no window before the new pixel 10; outputs match scenario 1 exactly.
5. Default 28x28 with p = (28r+c) mod 256 → 676 windows. Each win_r_c equals (28(r0+r)+(c0+c)) mod 256; the scoreboard checks all windows.
6. Reset values → during rst=0: win_valid_out=0, frame_done=0, win_*=0, pix_ready_out=1.

Source files
------------

// File: rtl/conv33_window.sv
// rtl/conv33_window.sv - raster pixel stream to 3x3 sliding windows for the convolution core
module conv33_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid_in,
    output logic                  pix_ready_out,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  win_valid_out,
    input  logic                  win_ready_in,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(2);
    localparam logic [RW-1:0] ROW_WIN  = RW'(2);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_win_valid;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] r_win [3][3];

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_win_ok;
    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;

    assign pix_ready_out = !r_win_valid || win_ready_in;
    assign w_accept      = pix_valid_in && pix_ready_out;
    assign w_col_last    = (r_col == COL_LAST);
    assign w_row_last    = (r_row == ROW_LAST);
    assign w_win_ok      = (r_row >= ROW_WIN) && (r_col >= COL_WIN);
    assign w_lb0_rd      = r_lb0[r_col];
    assign w_lb1_rd      = r_lb1[r_col];

    // Line buffers carry no reset: stale rows are masked by the row gate.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // The shift register doubles as the output stage; it only moves on a pixel accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                r_win_valid <= w_win_ok;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb0_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= pix_data;
            end else if (win_ready_in) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_valid_out = r_win_valid;
    assign frame_done    = r_frame_done;
    assign win_0_0       = r_win[0][0];
    assign win_0_1       = r_win[0][1];
    assign win_0_2       = r_win[0][2];
    assign win_1_0       = r_win[1][0];
    assign win_1_1       = r_win[1][1];
    assign win_1_2       = r_win[1][2];
    assign win_2_0       = r_win[2][0];
    assign win_2_1       = r_win[2][1];
    assign win_2_2       = r_win[2][2];

endmodule
